// File: rtl/audio_pkg.sv
// Shared constants and state type for the audio frame serializer.
package audio_pkg;

  localparam int unsigned SLOT_W     = 16;
  localparam int unsigned FRAME_BITS = 32;
  localparam logic [4:0]  LAST_BIT   = 5'd31;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/audio_sample_hold.sv
// One-entry stereo sample holding register with valid/ready intake, load-drain and clear.
module audio_sample_hold #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  output logic              sample_ready,
  output logic              hold_full,
  output logic [DATA_W-1:0] hold_l,
  output logic [DATA_W-1:0] hold_r
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] l_q, l_d, r_q, r_d;
  logic              accept;

  always_comb begin
    // A load frees the entry on the same edge, so a new sample may land while the old one leaves.
    sample_ready = reset & enable & (~full_q | load);
    accept       = sample_valid & sample_ready;
    full_d       = full_q;
    l_d          = l_q;
    r_d          = r_q;
    if (!enable) begin
      full_d = 1'b0;
    end else if (accept) begin
      full_d = 1'b1;
      l_d    = sample_l;
      r_d    = sample_r;
    end else if (load) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      l_q    <= '0;
      r_q    <= '0;
    end else begin
      full_q <= full_d;
      l_q    <= l_d;
      r_q    <= r_d;
    end
  end

  assign hold_full = full_q;
  assign hold_l    = l_q;
  assign hold_r    = r_q;

endmodule

// File: rtl/audio_frame_serializer.sv
// Serializes stereo PCM samples into 32-bit I2S-style frames framed by an external bit counter.
module audio_frame_serializer
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned UNDR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  bit_tick,
  input  logic [4:0]            bit_cnt,
  input  logic                  sample_valid,
  input  logic [DATA_W-1:0]     sample_l,
  input  logic [DATA_W-1:0]     sample_r,
  output logic                  sample_ready,
  output logic                  sdata,
  output logic                  lrclk,
  output logic                  frame_start,
  output logic                  underrun,
  output logic [UNDR_CNT_W-1:0] underrun_cnt
);

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic                    lrclk_q, lrclk_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;
  logic [UNDR_CNT_W-1:0]   cnt_q, cnt_d;

  logic                    load;
  logic                    hold_full;
  logic [DATA_W-1:0]       hold_l, hold_r;
  logic [SLOT_W-1:0]       slot_l, slot_r;
  logic [4:0]              bit_cnt_next;

  assign load         = enable & bit_tick & (bit_cnt == LAST_BIT);
  assign bit_cnt_next = bit_cnt + 5'd1;
  // Narrow samples are left-justified in the slot with zero LSBs.
  assign slot_l       = SLOT_W'(hold_l) << (SLOT_W - DATA_W);
  assign slot_r       = SLOT_W'(hold_r) << (SLOT_W - DATA_W);

  audio_sample_hold #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .load         (load),
    .sample_valid (sample_valid),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_ready (sample_ready),
    .hold_full    (hold_full),
    .hold_l       (hold_l),
    .hold_r       (hold_r)
  );

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    lrclk_d       = lrclk_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    cnt_d         = cnt_q;
    if (!enable) begin
      state_d = IDLE;
      shreg_d = '0;
      lrclk_d = 1'b0;
    end else begin
      if (load) begin
        frame_start_d = (state_q == RUN) | hold_full;
        underrun_d    = (state_q == RUN) & ~hold_full;
        shreg_d       = hold_full ? {slot_l, slot_r} : '0;
        if (hold_full) state_d = RUN;
      end else if (state_q == IDLE) begin
        shreg_d = '0;
      end else if (bit_tick) begin
        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
      end
      // lrclk tracks the slot of the bit that sdata presents after this tick.
      if (bit_tick) lrclk_d = bit_cnt_next[4];
      if (underrun_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      lrclk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      lrclk_q       <= lrclk_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      cnt_q         <= cnt_d;
    end
  end

  assign sdata        = shreg_q[FRAME_BITS-1];
  assign lrclk        = lrclk_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = cnt_q;

endmodule
